// File: rtl/writeback_pkg.sv
// Shared constants, request record and helpers for the register-file writeback arbiter.
package writeback_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int N_REGS     = 32;
  localparam int N_REQ      = 3;
  localparam int REQ_IDX_W  = $clog2(N_REQ);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  function automatic logic [N_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = N_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts just after the last winner and wraps.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // First requesting candidate after last wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    cand_s    = '0;
    for (int off = 1; off <= N; off++) begin
      cand_s = IDX_W'((int'(last) + off) % N);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin owner of the register-file write port with a pending-write scoreboard
// for issue-stage hazard checks.
module writeback_arbiter
  import writeback_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            Req_valid,
  input  logic [N_REQ*REG_ADDR_W-1:0] Req_rd,
  input  logic [N_REQ*XLEN-1:0]       Req_data,
  output logic [N_REQ-1:0]            Req_ready,
  input  logic                        Claim_valid,
  input  logic [REG_ADDR_W-1:0]       Claim_rd,
  input  logic [REG_ADDR_W-1:0]       RS1,
  input  logic [REG_ADDR_W-1:0]       RS2,
  output logic                        RS1_busy,
  output logic                        RS2_busy,
  output logic [N_REGS-1:0]           Busy_vec,
  output logic                        Reg_write,
  output logic [REG_ADDR_W-1:0]       RD,
  output logic [XLEN-1:0]             Write_data
);

  wb_req_t              req_s [N_REQ];
  wb_req_t              sel_s;
  logic [N_REQ-1:0]     grant_s;
  logic [REQ_IDX_W-1:0] grant_idx_s;
  logic [REQ_IDX_W-1:0] last_r;
  logic                 accept_s;

  logic                  reg_write_r;
  logic [REG_ADDR_W-1:0] rd_r;
  logic [XLEN-1:0]       data_r;

  logic [N_REGS-1:0] busy_r;
  logic [N_REGS-1:0] busy_next_s;
  logic [N_REGS-1:0] set_s;
  logic [N_REGS-1:0] clr_s;

  // Split the flat request buses into per-requester records
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_s[i].rd   = Req_rd[REG_ADDR_W*i +: REG_ADDR_W];
      req_s[i].data = Req_data[XLEN*i +: XLEN];
    end
  end

  rr_arbiter #(.N(N_REQ), .IDX_W(REQ_IDX_W)) u_rr (
    .req       (Req_valid),
    .last      (last_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign Req_ready = grant_s;
  assign accept_s  = |grant_s;
  assign sel_s     = req_s[grant_idx_s];

  // Write-port stage; rd 0 is consumed but never reaches the register file
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_r <= 1'b0;
      rd_r        <= '0;
      data_r      <= '0;
      last_r      <= REQ_IDX_W'(N_REQ - 1);
    end else if (accept_s) begin
      last_r      <= grant_idx_s;
      reg_write_r <= (sel_s.rd != '0);
      rd_r        <= sel_s.rd;
      data_r      <= sel_s.data;
    end else begin
      reg_write_r <= 1'b0;
    end
  end

  // Clear the committing destination, then apply the claim so a same-edge claim wins
  always_comb begin
    clr_s       = reg_write_r ? reg_onehot(rd_r) : '0;
    set_s       = (Claim_valid && (Claim_rd != '0)) ? reg_onehot(Claim_rd) : '0;
    busy_next_s = ((busy_r & ~clr_s) | set_s) & ~N_REGS'(1);
  end

  // Pending-write scoreboard
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign Reg_write  = reg_write_r;
  assign RD         = rd_r;
  assign Write_data = data_r;
  assign Busy_vec   = busy_r;
  assign RS1_busy   = busy_r[RS1];
  assign RS2_busy   = busy_r[RS2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench for writeback_arbiter: directed scenarios plus randomized traffic
// checked against an abstract round-robin / pending-set model.
module tb_writeback_arbiter;
  import writeback_pkg::*;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [N_REQ-1:0]            Req_valid;
  logic [N_REQ*REG_ADDR_W-1:0] Req_rd;
  logic [N_REQ*XLEN-1:0]       Req_data;
  logic [N_REQ-1:0]            Req_ready;
  logic                        Claim_valid;
  logic [REG_ADDR_W-1:0]       Claim_rd;
  logic [REG_ADDR_W-1:0]       RS1, RS2;
  logic                        RS1_busy, RS2_busy;
  logic [N_REGS-1:0]           Busy_vec;
  logic                        Reg_write;
  logic [REG_ADDR_W-1:0]       RD;
  logic [XLEN-1:0]             Write_data;

  writeback_arbiter dut (
    .clk(clk), .reset(reset), .Req_valid(Req_valid), .Req_rd(Req_rd), .Req_data(Req_data),
    .Req_ready(Req_ready), .Claim_valid(Claim_valid), .Claim_rd(Claim_rd), .RS1(RS1), .RS2(RS2),
    .RS1_busy(RS1_busy), .RS2_busy(RS2_busy), .Busy_vec(Busy_vec), .Reg_write(Reg_write),
    .RD(RD), .Write_data(Write_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [63:0] data; } wr_t;

  int  n_checks = 0;
  int  n_fail   = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  // reference model state
  int  mdl_last = N_REQ - 1;
  bit  mdl_busy [32];
  bit  mdl_cv   = 1'b0;
  int  mdl_crd  = 0;
  int  mdl_g;
  logic [4:0] mdl_rd;

  // stimulus state
  bit          pend   [3];
  logic [4:0]  s_rd   [3];
  logic [63:0] s_data [3];
  bit          c_v    = 1'b0;
  logic [4:0]  c_rd   = 5'd0;
  logic [4:0]  s_rs1  = 5'd0;
  logic [4:0]  s_rs2  = 5'd0;
  int          last_g;
  int          tbl [6] = '{0, 1, 2, 0, 1, 2};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_grant(input bit [2:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++) begin
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] busy_word();
    logic [31:0] w;
    w = 32'd0;
    for (int r = 0; r < 32; r++) w[r] = mdl_busy[r];
    return w;
  endfunction

  // Reference model: round-robin winner, expected writes, pending destination set
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mdl_last = N_REQ - 1;
      foreach (mdl_busy[r]) mdl_busy[r] = 1'b0;
      mdl_cv = 1'b0;
      exp_q.delete();
    end else begin
      mdl_g = exp_grant(Req_valid, mdl_last);
      if (mdl_cv) mdl_busy[mdl_crd] = 1'b0;
      if (Claim_valid && Claim_rd != 5'd0) mdl_busy[Claim_rd] = 1'b1;
      mdl_cv = 1'b0;
      if (mdl_g >= 0) begin
        mdl_last = mdl_g;
        mdl_rd   = Req_rd[5*mdl_g +: 5];
        if (mdl_rd != 5'd0) begin
          exp_q.push_back('{rd: mdl_rd, data: Req_data[64*mdl_g +: 64]});
          mdl_cv  = 1'b1;
          mdl_crd = int'(mdl_rd);
        end
      end
    end
  end

  // Monitor: each low phase, compare the write port and scoreboard with the model
  initial forever begin
    @(negedge clk);
    if (reset !== 1'b1) begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("reg_write", 64'(Reg_write), 64'd1);
        check("rd", 64'(RD), 64'(mon_e.rd));
        check("write_data", Write_data, mon_e.data);
      end else begin
        check("reg_write_idle", 64'(Reg_write), 64'd0);
      end
      check("busy_vec", 64'(Busy_vec), 64'(busy_word()));
    end
  end

  task automatic step(input bit auto_clr);
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      Req_valid[i]          = pend[i];
      Req_rd[5*i +: 5]      = s_rd[i];
      Req_data[64*i +: 64]  = s_data[i];
    end
    Claim_valid = c_v;
    Claim_rd    = c_rd;
    RS1         = s_rs1;
    RS2         = s_rs2;
    #1;
    last_g = exp_grant(Req_valid, mdl_last);
    check("req_ready", 64'(Req_ready), (last_g >= 0) ? (64'd1 << last_g) : 64'd0);
    check("rs1_busy", 64'(RS1_busy), 64'(mdl_busy[RS1]));
    check("rs2_busy", 64'(RS2_busy), 64'(mdl_busy[RS2]));
    if (auto_clr && last_g >= 0) pend[last_g] = 1'b0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [4:0] rd, input logic [63:0] d);
    pend[i] = v; s_rd[i] = rd; s_data[i] = d;
  endtask

  initial begin
    reset = 1'b1; Req_valid = 3'd0; Req_rd = '0; Req_data = '0;
    Claim_valid = 1'b0; Claim_rd = 5'd0; RS1 = 5'd3; RS2 = 5'd7;
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 5'd0, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_reg_write", 64'(Reg_write), 64'd0);
    check("rst_rd", 64'(RD), 64'd0);
    check("rst_write_data", Write_data, 64'd0);
    check("rst_busy_vec", 64'(Busy_vec), 64'd0);
    check("rst_rs1_busy", 64'(RS1_busy), 64'd0);
    check("rst_rs2_busy", 64'(RS2_busy), 64'd0);

    // all three requesters continuously valid
    set_req(0, 1'b1, 5'd5, 64'hA);
    set_req(1, 1'b1, 5'd6, 64'hB);
    set_req(2, 1'b1, 5'd7, 64'hC);
    for (int k = 0; k < 6; k++) begin
      step(1'b0);
      check("rr_sequence", 64'(Req_ready), 64'd1 << tbl[k]);
    end
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;

    // claim rd 12, then requester 1 writes it three edges later
    c_v = 1'b1; c_rd = 5'd12; s_rs1 = 5'd12;
    step(1'b0);
    c_v = 1'b0;
    step(1'b0);
    check("rs1_busy_after_claim", 64'(RS1_busy), 64'd1);
    step(1'b0);
    set_req(1, 1'b1, 5'd12, 64'h1234);
    step(1'b0);
    pend[1] = 1'b0;
    step(1'b0);
    check("rd12_write", 64'(Reg_write), 64'd1);
    check("rd12_index", 64'(RD), 64'd12);
    check("rs1_busy_in_write_cycle", 64'(RS1_busy), 64'd1);
    step(1'b0);
    check("rs1_busy_cleared", 64'(RS1_busy), 64'd0);

    // rd 0 is granted but never written; pointer still advances
    set_req(0, 1'b1, 5'd0, 64'hFF);
    set_req(1, 1'b1, 5'd9, 64'h99);
    step(1'b0);
    check("rd0_granted", 64'(Req_ready), 64'd1);
    pend[0] = 1'b0;
    step(1'b0);
    check("rd0_no_write", 64'(Reg_write), 64'd0);
    check("after_rd0_grant1", 64'(Req_ready), 64'd2);
    pend[1] = 1'b0;
    step(1'b0);

    // claim of rd 5 on the edge its write commits keeps it busy
    set_req(2, 1'b1, 5'd5, 64'h55);
    step(1'b0);
    pend[2] = 1'b0;
    c_v = 1'b1; c_rd = 5'd5;
    step(1'b0);
    c_v = 1'b0;
    step(1'b0);
    check("busy5_set_wins", 64'(Busy_vec[5]), 64'd1);

    // randomized traffic, requests held until accepted
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]   = 1'b1;
          s_rd[i]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          s_data[i] = {$urandom, $urandom};
        end
      end
      c_v   = ($urandom_range(0, 3) == 0);
      c_rd  = 5'($urandom_range(0, 31));
      s_rs1 = 5'($urandom_range(0, 31));
      s_rs2 = 5'($urandom_range(0, 31));
      step(1'b1);
    end
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    c_v = 1'b0;
    repeat (3) step(1'b0);

    // asynchronous reset mid-cycle while a write is in flight
    set_req(0, 1'b1, 5'd21, 64'h21);
    set_req(1, 1'b1, 5'd22, 64'h22);
    set_req(2, 1'b1, 5'd23, 64'h23);
    c_v = 1'b1; c_rd = 5'd20;
    step(1'b0);
    c_v = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_write", 64'(Reg_write), 64'd1);
    check("pre_reset_busy20", 64'(Busy_vec[20]), 64'd1);
    reset = 1'b1;
    #1;
    check("async_rst_reg_write", 64'(Reg_write), 64'd0);
    check("async_rst_busy_vec", 64'(Busy_vec), 64'd0);
    check("async_rst_rd", 64'(RD), 64'd0);
    check("async_rst_data", Write_data, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rearb_from_req0", 64'(Req_ready), 64'd1);
    for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    repeat (3) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the register file's single write port among several writeback requesters (ALU, load unit, multi-cycle mul/div) and tracks pending destination writes for hazard detection. Sits between the execute/memory stages and the register file: drives its `RD`, `Write_data` and `Reg_write` inputs from a registered stage, and exposes per-source-register busy flags to the issue logic.

## Interface
- `N_REQ`, 3, number of writeback requesters
- `XLEN`, 64, data width
- `REG_ADDR_W`, 5, register index width (32 registers)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high
- `Req_valid`  in  N_REQ  requester i has a write pending
- `Req_rd`  in  N_REQ*REG_ADDR_W  requester i destination at [REG_ADDR_W*i +: REG_ADDR_W]
- `Req_data`  in  N_REQ*XLEN  requester i data at [XLEN*i +: XLEN]
- `Req_ready`  out  N_REQ  one-hot grant; accept when valid & ready
- `Claim_valid`  in  1  issue stage reserves a destination this cycle
- `Claim_rd`  in  REG_ADDR_W  register being reserved
- `RS1`, `RS2`  in  REG_ADDR_W  source indices under hazard check
- `RS1_busy`, `RS2_busy`  out  1  source has an uncommitted write
- `Busy_vec`  out  32  full scoreboard
- `Reg_write`  out  1  register-file write enable
- `RD`  out  REG_ADDR_W  register-file write index
- `Write_data`  out  XLEN  register-file write data

## Operation
- Arbitration: round-robin. Pointer `last` (reset N_REQ-1) names the most recent winner; search starts at last+1, wraps. At most one `Req_ready` bit high; zero when no valid. Ready depends combinationally on `Req_valid`; requesters must not make valid depend on ready.
- Accept: valid & ready on requester i at an edge → `last` := i; `Reg_write` := (rd≠0); `RD`, `Write_data` := request fields.
- No accept: `Reg_write` := 0; `RD`, `Write_data` hold.
- rd = 0: still accepted (ready asserted, pointer advances) but never produces `Reg_write`=1.
- Requesters hold valid/rd/data stable until accepted.
- Scoreboard `Busy_vec`: set bit r at edge with `Claim_valid` & `Claim_rd`=r≠0; clear bit `RD` at edge with `Reg_write`=1 (the edge the register file commits). Same-edge set and clear of same bit → set wins. Set on an already-busy bit is idempotent. Bit 0 constant 0.
- `RSn_busy` = `Busy_vec[RSn]`, combinational.

## Timing
- `Req_ready`: same cycle as valid (combinational).
- Accept edge → `Reg_write` high next cycle → register file commits at following edge.
- Busy visible the cycle after the claim edge; remains 1 through the cycle `Reg_write` targets it; 0 from the next cycle.
- Throughput: one write per cycle; the register-file port never back-pressures.
- Reset values: `Reg_write` 0, `RD` 0, `Write_data` 0, `Busy_vec` 0, `last` N_REQ-1. Reset mid-operation drops any in-flight write immediately (no clock required); requests pending at reset release are rearbitrated from requester 0.

## Structure
- Package `writeback_pkg`: `XLEN`, `REG_ADDR_W`, `N_REGS`=32, `N_REQ` constants; typedef `wb_req_t` {rd, data}.
- Sub-module `rr_arbiter` (parameter N; inputs req, last; output one-hot grant and encoded index), purely combinational; pointer register stays in `writeback_arbiter`.

## Test plan
- Reset: assert `reset` for 2 cycles → `Reg_write`=0, `RD`=0, `Write_data`=0, `Busy_vec`=0, `RSn_busy`=0.
- All three valid continuously, rd 5/6/7, data 0xA/0xB/0xC → grants 0,1,2,0,1,2; `Reg_write`=1 every cycle with matching RD/data one cycle after each grant.
- Claim rd=12 at edge t → `RS1_busy` (RS1=12) high from t+1; requester 1 writes rd 12 data 0x1234 accepted at edge t+3 → `Reg_write`=1, RD=12 in cycle after t+3, `RS1_busy` still 1 there, 0 after edge t+4.
- Requester 0 rd=0 data 0xFF → `Req_ready[0]`=1, `Reg_write` stays 0, next grant goes to requester 1 if valid.
- Claim rd=5 on the same edge a write to rd 5 commits → `Busy_vec[5]` remains 1.
- Assert `reset` asynchronously mid-cycle while `Reg_write`=1, `Busy_vec`≠0 → `Reg_write` and `Busy_vec` go 0 before next clock edge.
